// File: rtl/pipe_adder_pkg.sv
// Shared constants and configuration check for the pipelined N-bit adder.
package pipe_adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Legal when the carry chain splits into SEGS equal, non-empty slices.
  function automatic bit width_segs_ok(input int width, input int segs);
    return (segs >= 1) && (segs <= width) && ((width % segs) == 0);
  endfunction

endpackage

// File: rtl/pipe_adder_seg.sv
// One carry-chain slice: S-bit add with registered carry-out and valid bit.
// The slice sum is combinational; the top level owns its deskew storage.
module pipe_adder_seg
  import pipe_adder_pkg::*;
#(
  parameter int S = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         in_valid,
  input  logic [S-1:0] a,
  input  logic [S-1:0] b,
  input  logic         ci,
  output logic [S-1:0] sum,
  output logic         co,
  output logic         out_valid
);

  logic [S:0] total;
  logic       co_reg;
  logic       valid_reg;

  assign total = {1'b0, a} + {1'b0, b} + {{S{1'b0}}, ci};
  assign sum   = total[S-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      co_reg    <= 1'b0;
      valid_reg <= 1'b0;
    end else if (en) begin
      co_reg    <= total[S];
      valid_reg <= in_valid;
    end
  end

  assign co        = co_reg;
  assign out_valid = valid_reg;

endmodule

// File: rtl/pipe_nbit_adder.sv
// Pipelined add/sub with valid/ready handshake, one register stage per carry slice.
// Optional PIPE_NBIT_ADDER_SAT_EN: clamp overflowed results to the signed extreme.
module pipe_nbit_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEGS  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);

  localparam int S = (SEGS >= 1) ? (WIDTH / SEGS) : WIDTH;

  if (!width_segs_ok(WIDTH, SEGS)) begin : g_cfg_err
    $error("pipe_nbit_adder: WIDTH must be a multiple of SEGS and SEGS must be in 1..WIDTH");
  end

  logic             stall;
  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  // Stall is global; ready depends only on the output side.
  assign stall    = out_valid && !out_ready;
  assign en       = !stall;
  assign in_ready = !stall;

  assign b_eff = (op == OP_SUB) ? ~b : b;
  assign c_eff = (op == OP_SUB) ? ~ci : ci;

  genvar gi;
  for (gi = 0; gi < SEGS; gi++) begin : g_stage
    localparam int LO = (gi + 1) * S;

    logic [S-1:0] sa;
    logic [S-1:0] sb;
    logic [S-1:0] ss;
    logic         sc;
    logic         sv;
    logic         am;
    logic         bm;
    logic         cout;
    logic         vout;

    if (gi == 0) begin : g_src
      assign sa = a[S-1:0];
      assign sb = b_eff[S-1:0];
      assign sc = c_eff;
      assign sv = in_valid;
      assign am = a[WIDTH-1];
      assign bm = b_eff[WIDTH-1];
    end else begin : g_src
      assign sa = g_stage[gi-1].g_mid.a_reg[S-1:0];
      assign sb = g_stage[gi-1].g_mid.b_reg[S-1:0];
      assign sc = g_stage[gi-1].cout;
      assign sv = g_stage[gi-1].vout;
      assign am = g_stage[gi-1].g_mid.am_reg;
      assign bm = g_stage[gi-1].g_mid.bm_reg;
    end

    pipe_adder_seg #(.S(S)) u_seg (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .in_valid  (sv),
      .a         (sa),
      .b         (sb),
      .ci        (sc),
      .sum       (ss),
      .co        (cout),
      .out_valid (vout)
    );

    if (gi < SEGS - 1) begin : g_mid
      // Skew holds operand slices still to be added; deskew holds finished low slices.
      localparam int R = WIDTH - LO;

      logic [R-1:0]  a_reg;
      logic [R-1:0]  b_reg;
      logic [LO-1:0] sum_reg;
      logic          am_reg;
      logic          bm_reg;
      logic [R-1:0]  a_next;
      logic [R-1:0]  b_next;
      logic [LO-1:0] sum_next;

      if (gi == 0) begin : g_ld
        assign a_next   = a[WIDTH-1:S];
        assign b_next   = b_eff[WIDTH-1:S];
        assign sum_next = ss;
      end else begin : g_ld
        assign a_next   = g_stage[gi-1].g_mid.a_reg[R+S-1:S];
        assign b_next   = g_stage[gi-1].g_mid.b_reg[R+S-1:S];
        assign sum_next = {ss, g_stage[gi-1].g_mid.sum_reg};
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_reg   <= '0;
          b_reg   <= '0;
          sum_reg <= '0;
          am_reg  <= 1'b0;
          bm_reg  <= 1'b0;
        end else if (en) begin
          a_reg   <= a_next;
          b_reg   <= b_next;
          sum_reg <= sum_next;
          am_reg  <= am;
          bm_reg  <= bm;
        end
      end
    end else begin : g_last
      logic [WIDTH-1:0] full;
      logic [WIDTH-1:0] res;
      logic             ovf_next;
      logic [WIDTH-1:0] sum_reg;
      logic             ovf_reg;

      if (gi == 0) begin : g_join
        assign full = ss;
      end else begin : g_join
        assign full = {ss, g_stage[gi-1].g_mid.sum_reg};
      end

      assign ovf_next = (am == bm) && (full[WIDTH-1] != am);

`ifdef PIPE_NBIT_ADDER_SAT_EN
      assign res = !ovf_next ? full :
                   am ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
      assign res = full;
`endif

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum_reg <= '0;
          ovf_reg <= 1'b0;
        end else if (en) begin
          sum_reg <= res;
          ovf_reg <= ovf_next;
        end
      end

      assign sum       = sum_reg;
      assign ovf       = ovf_reg;
      assign co        = cout;
      assign out_valid = vout;
    end
  end

endmodule
